bitwise_arbiter: RTL

BITWISE_ARBITER -- requirements
Module: bitwise_arbiter

---
 rtl/bitwise_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bitwise_arbiter.sv
// bitwise_arbiter
//   Two-requester round-robin arbiter in front of a single-entry result
//   register. The granted requester's operands are combined bit-parallel
//   (AND / OR / XOR / NOR) and the result is registered with latency 1.
//
// Parameters
//   WIDTH        operand / result width in bits (default 32)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req{0,1}_valid/ready     requester handshakes (ready is combinational)
//   req{0,1}_op              opcode 00 AND, 01 OR, 10 XOR, 11 NOR
//   req{0,1}_x / _y          operands
//   res_valid/res_ready      result handshake
//   res_data, res_id         registered result and owning requester
//   op_count                 16-bit wrapping count of result transfers
//   res_zero                 (only with BITWISE_ARBITER_ZERO_FLAG_EN)
//                            registered all-zero flag for res_data
//
// Optional feature macro: BITWISE_ARBITER_ZERO_FLAG_EN

// One bit-slice of the logic unit. Slices have no cross-lane dependency.
module bitwise_lane #(
  parameter int VEC_W = 1
) (
  input  logic [1:0]       op,
  input  logic [VEC_W-1:0] x,
  input  logic [VEC_W-1:0] y,
  output logic [VEC_W-1:0] z
);
  always_comb begin
    z = '0;
    case (op)
      2'b00:   z = x & y;
      2'b01:   z = x | y;
      2'b10:   z = x ^ y;
      default: z = ~(x | y);
    endcase
  end
endmodule

module bitwise_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
`ifdef BITWISE_ARBITER_ZERO_FLAG_EN
  output logic             res_zero,
`endif
  output logic [15:0]      op_count
);
  localparam int VEC_W     = 1;
  localparam int NUM_LANES = WIDTH / VEC_W;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } req_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state;
  logic   last_grant;
  logic   slot_free, grant0, grant1, grant;
  req_t   r0, r1, sel;

  logic [NUM_LANES-1:0][VEC_W-1:0] x_lanes, y_lanes, z_lanes;
  logic [WIDTH-1:0] z;

  assign res_valid = (state == FULL);

  // Slot can take a new result if empty or being drained this cycle.
  assign slot_free = !res_valid || res_ready;

  // Tie goes to whoever was not granted last; readies are held low in reset.
  assign grant0 = !rst && slot_free && req0_valid && (!req1_valid || last_grant);
  assign grant1 = !rst && slot_free && req1_valid && (!req0_valid || !last_grant);
  assign grant  = grant0 || grant1;

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign r0 = '{op: req0_op, x: req0_x, y: req0_y};
  assign r1 = '{op: req1_op, x: req1_x, y: req1_y};
  assign sel = grant1 ? r1 : r0;

  assign x_lanes = sel.x;
  assign y_lanes = sel.y;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    bitwise_lane #(.VEC_W(VEC_W)) u_lane (
      .op (sel.op),
      .x  (x_lanes[l]),
      .y  (y_lanes[l]),
      .z  (z_lanes[l])
    );
  end

  assign z = z_lanes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      res_data   <= '0;
      res_id     <= 1'b0;
      op_count   <= 16'd0;
      last_grant <= 1'b1;
`ifdef BITWISE_ARBITER_ZERO_FLAG_EN
      res_zero   <= 1'b0;
`endif
    end else begin
      if (res_valid && res_ready) op_count <= op_count + 16'd1;
      if (grant) begin
        res_data   <= z;
        res_id     <= grant1;
        last_grant <= grant1;
`ifdef BITWISE_ARBITER_ZERO_FLAG_EN
        res_zero   <= (z == '0);
`endif
      end
      case (state)
        EMPTY:   if (grant) state <= FULL;
        FULL:    if (res_ready && !grant) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end
endmodule
